// File: rtl/graph_pkg.sv
// ---------------------------------------------------------------------------
// graph_pkg
// Shared definitions for the query scheduler: FSM state encoding, the
// reserved result codes written in place of a path cost, and a helper that
// folds an engine outcome into the 16-bit word stored in output memory.
// ---------------------------------------------------------------------------
package graph_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_COUNT,
      S_RD_SRC,
      S_RD_DST,
      S_START,
      S_WAIT,
      S_WR_RES,
      S_DONE
   } state_e;

   // Reserved result codes; real path costs never use these two values.
   localparam logic [15:0] RES_NO_PATH = 16'hFFFF;
   localparam logic [15:0] RES_TIMEOUT = 16'hFFFE;

   // Result word for one query. A finish always wins over a timeout seen in
   // the same cycle, so the caller passes finish=0 only when it timed out.
   function automatic logic [15:0] result_code(input logic        i_finish,
                                                input logic        i_n_exist,
                                                input logic [15:0] i_cost);
      if (!i_finish)      return RES_TIMEOUT;
      else if (i_n_exist) return RES_NO_PATH;
      else                return i_cost;
   endfunction

endpackage

// File: rtl/query_scheduler_if.sv
// ---------------------------------------------------------------------------
// query_scheduler_if
// Bus bundle between the scheduler and its environment.
//   InputAddress/InputRead           query-list read port (combinational read)
//   engine_start/source/dest         shortest-path engine launch
//   engine_finish/n_exist/cost       engine completion and result
//   WE2/output_memory_address/value  result write port
// master = scheduler side, slave = memories + engine side.
// ---------------------------------------------------------------------------
interface query_scheduler_if;

   logic [9:0]  InputAddress;
   logic [7:0]  InputRead;
   logic        engine_start;
   logic [7:0]  engine_source;
   logic [7:0]  engine_dest;
   logic        engine_finish;
   logic        engine_n_exist;
   logic [15:0] engine_cost;
   logic        WE2;
   logic [13:0] output_memory_address;
   logic [15:0] output_memory_value;

   modport master (
      output InputAddress,
      input  InputRead,
      output engine_start, engine_source, engine_dest,
      input  engine_finish, engine_n_exist, engine_cost,
      output WE2, output_memory_address, output_memory_value
   );

   modport slave (
      input  InputAddress,
      output InputRead,
      input  engine_start, engine_source, engine_dest,
      output engine_finish, engine_n_exist, engine_cost,
      input  WE2, output_memory_address, output_memory_value
   );

endinterface

// File: rtl/query_scheduler_wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Counts cycles spent in WAIT for the current query.
//   clock, reset  clock / asynchronous active-low reset
//   i_run         high while the scheduler is in WAIT; low clears the count
//   o_expired     high during the TIMEOUT_CYCLES-th consecutive run cycle
// ---------------------------------------------------------------------------
module wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic clock,
   input  logic reset,
   input  logic i_run,
   output logic o_expired
);

   localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYCLES);

   logic [15:0] r_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                r_count <= '0;
      else if (!i_run)           r_count <= '0;
      else if (r_count != '1)    r_count <= r_count + 16'd1;
   end

   // r_count holds the number of WAIT cycles already completed, so the
   // current cycle is number r_count+1.
   assign o_expired = i_run && (({1'b0, r_count} + 17'd1) >= LIMIT);

endmodule

// File: rtl/query_scheduler.sv
// ---------------------------------------------------------------------------
// query_scheduler
// Reads a list of N (source, dest) queries from input memory, launches the
// shortest-path engine once per query, and writes one 16-bit result word per
// query to output memory (cost, 16'hFFFF no path, 16'hFFFE timeout).
//   clock, reset   clock / asynchronous active-low reset
//   go             start request, honoured only in IDLE or DONE
//   bus            query_scheduler_if.master (memory + engine signals)
//   busy, done     busy outside IDLE/DONE; done only in DONE
//   timeout_flag   sticky: some query of this run timed out
//   queries_done   queries completed in this run
// ---------------------------------------------------------------------------
module query_scheduler
   import graph_pkg::*;
#(
   parameter logic [9:0]  INPUT_BASE     = 10'd0,
   parameter logic [13:0] RESULT_BASE    = 14'd0,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   query_scheduler_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              timeout_flag,
   output logic [7:0]        queries_done
);

   state_e      r_state, w_next_state;
   logic [7:0]  r_n, r_i, r_src, r_dst, r_queries_done;
   logic [15:0] r_result;
   logic        r_timeout_flag;
   logic        w_expired;

   wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
      .clock     (clock),
      .reset     (reset),
      .i_run     (r_state == S_WAIT),
      .o_expired (w_expired)
   );

   // Source/dest come straight from their latches, so they stay stable from
   // START through WAIT and read 0 after reset.
   assign bus.engine_source = r_src;
   assign bus.engine_dest   = r_dst;
   assign timeout_flag      = r_timeout_flag;
   assign queries_done      = r_queries_done;

   always_comb begin
      // NOTE: every signal gets a default first so no branch leaves one
      // unassigned, which would otherwise infer a latch.
      w_next_state              = r_state;
      bus.InputAddress          = '0;
      bus.engine_start          = 1'b0;
      bus.WE2                   = 1'b0;
      bus.output_memory_address = '0;
      bus.output_memory_value   = '0;
      busy                      = 1'b1;
      done                      = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (go) w_next_state = S_RD_COUNT;
         end
         S_RD_COUNT: begin
            bus.InputAddress = INPUT_BASE;
            w_next_state     = (bus.InputRead == 8'd0) ? S_DONE : S_RD_SRC;
         end
         S_RD_SRC: begin
            bus.InputAddress = INPUT_BASE + 10'd1 + {1'b0, r_i, 1'b0};
            w_next_state     = S_RD_DST;
         end
         S_RD_DST: begin
            bus.InputAddress = INPUT_BASE + 10'd2 + {1'b0, r_i, 1'b0};
            w_next_state     = S_START;
         end
         S_START: begin
            bus.engine_start = 1'b1;
            w_next_state     = S_WAIT;
         end
         S_WAIT: begin
            if (bus.engine_finish || w_expired) w_next_state = S_WR_RES;
         end
         S_WR_RES: begin
            bus.WE2                   = 1'b1;
            bus.output_memory_address = RESULT_BASE + {6'd0, r_i};
            bus.output_memory_value   = r_result;
            w_next_state              = (r_i == r_n - 8'd1) ? S_DONE : S_RD_SRC;
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (go) w_next_state = S_RD_COUNT;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_n            <= '0;
         r_i            <= '0;
         r_src          <= '0;
         r_dst          <= '0;
         r_result       <= '0;
         r_queries_done <= '0;
         r_timeout_flag <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values present before the edge, independent of statement order.
         r_state <= w_next_state;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (go) begin
                  r_i            <= '0;
                  r_queries_done <= '0;
                  r_timeout_flag <= 1'b0;
               end
            end
            S_RD_COUNT: r_n   <= bus.InputRead;
            S_RD_SRC:   r_src <= bus.InputRead;
            S_RD_DST:   r_dst <= bus.InputRead;
            S_WAIT: begin
               if (bus.engine_finish || w_expired)
                  r_result <= result_code(bus.engine_finish, bus.engine_n_exist,
                                          bus.engine_cost);
               if (!bus.engine_finish && w_expired)
                  r_timeout_flag <= 1'b1;
            end
            S_WR_RES: begin
               r_i            <= r_i + 8'd1;
               r_queries_done <= r_queries_done + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_query_scheduler.sv
// ---------------------------------------------------------------------------
// tb_query_scheduler
// Two scheduler instances share one input memory:
//   dut_a  default parameters; engine answered by a latency model
//   dut_b  INPUT_BASE=100, RESULT_BASE=14'h3FFF, TIMEOUT_CYCLES=8; engine
//          driven by hand from the main sequence
// Expected result writes are queued when a run is set up and compared when
// the DUT raises WE2.
// ---------------------------------------------------------------------------
module tb_query_scheduler;

   typedef struct {
      logic [13:0] addr;
      logic [15:0] val;
   } wr_t;

   typedef struct {
      logic [7:0]  src;
      logic [7:0]  dst;
      logic [15:0] cost;
      logic        nx;
   } eng_t;

   logic clock;
   logic reset;
   logic go_a, go_b;
   logic a_busy, a_done, a_tflag;
   logic b_busy, b_done, b_tflag;
   logic [7:0] a_qd, b_qd;

   logic [7:0] mem [1024];

   int n_pass  = 0;
   int n_total = 0;

   wr_t  sb_a[$];
   wr_t  sb_b[$];
   eng_t eng_q[$];
   eng_t a_e;
   int   a_lat    = 10;
   int   a_cnt    = 0;
   int   a_starts = 0;
   int   a_writes = 0;

   query_scheduler_if a_if ();
   query_scheduler_if b_if ();

   assign a_if.InputRead = mem[a_if.InputAddress];
   assign b_if.InputRead = mem[b_if.InputAddress];

   query_scheduler dut_a (
      .clock        (clock),
      .reset        (reset),
      .go           (go_a),
      .bus          (a_if),
      .busy         (a_busy),
      .done         (a_done),
      .timeout_flag (a_tflag),
      .queries_done (a_qd)
   );

   query_scheduler #(
      .INPUT_BASE     (10'd100),
      .RESULT_BASE    (14'h3FFF),
      .TIMEOUT_CYCLES (8)
   ) dut_b (
      .clock        (clock),
      .reset        (reset),
      .go           (go_b),
      .bus          (b_if),
      .busy         (b_busy),
      .done         (b_done),
      .timeout_flag (b_tflag),
      .queries_done (b_qd)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Engine model for dut_a: finish pulses a_lat cycles after the start cycle.
   always @(negedge clock) begin
      a_if.engine_finish = 1'b0;
      if (!reset) begin
         a_cnt = 0;
      end else begin
         if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0) begin
               if (eng_q.size() > 0) begin
                  a_e = eng_q.pop_front();
                  a_if.engine_cost    = a_e.cost;
                  a_if.engine_n_exist = a_e.nx;
                  check("a_src_stable", a_if.engine_source, a_e.src);
                  check("a_dst_stable", a_if.engine_dest, a_e.dst);
               end
               a_if.engine_finish = 1'b1;
            end
         end
         if (a_if.engine_start) begin
            a_cnt = a_lat;
            if (eng_q.size() > 0) begin
               check("a_src_at_start", a_if.engine_source, eng_q[0].src);
               check("a_dst_at_start", a_if.engine_dest, eng_q[0].dst);
            end
         end
      end
   end

   // Result-write scoreboards.
   always @(negedge clock) begin
      if (a_if.engine_start) a_starts++;
      if (a_if.WE2) begin
         a_writes++;
         if (sb_a.size() == 0) check("a_unexpected_we2", 1, 0);
         else begin
            wr_t w;
            w = sb_a.pop_front();
            check("a_wr_addr", a_if.output_memory_address, w.addr);
            check("a_wr_value", a_if.output_memory_value, w.val);
         end
      end
      if (b_if.WE2) begin
         if (sb_b.size() == 0) check("b_unexpected_we2", 1, 0);
         else begin
            wr_t w;
            w = sb_b.pop_front();
            check("b_wr_addr", b_if.output_memory_address, w.addr);
            check("b_wr_value", b_if.output_memory_value, w.val);
         end
      end
   end

   task automatic wait_done(input bit use_b, input int max_cycles, input string tag);
      int k = 0;
      while (!(use_b ? b_done : a_done) && k < max_cycles) begin
         @(negedge clock);
         k++;
      end
      check(tag, use_b ? b_done : a_done, 1'b1);
   endtask

   task automatic wait_start_b(input int max_cycles, input string tag);
      int k = 0;
      while (!b_if.engine_start && k < max_cycles) begin
         @(negedge clock);
         k++;
      end
      check(tag, b_if.engine_start, 1'b1);
   endtask

   initial begin
      int writes0, starts0, lat;
      reset = 1'b0;
      go_a  = 1'b0;
      go_b  = 1'b0;
      a_if.engine_finish  = 1'b0;
      a_if.engine_n_exist = 1'b0;
      a_if.engine_cost    = '0;
      b_if.engine_finish  = 1'b0;
      b_if.engine_n_exist = 1'b0;
      b_if.engine_cost    = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'd0;

      // Reset state.
      repeat (2) @(negedge clock);
      check("rst_a_busy", a_busy, 0);
      check("rst_a_done", a_done, 0);
      check("rst_a_start", a_if.engine_start, 0);
      check("rst_a_we2", a_if.WE2, 0);
      check("rst_a_addr", a_if.InputAddress, 0);
      check("rst_b_busy", b_busy, 0);
      check("rst_b_tflag", b_tflag, 0);
      reset = 1'b1;
      @(negedge clock);
      check("idle_a_done", a_done, 0);

      // N = 0: RD_COUNT then DONE, no engine launch, no write.
      starts0 = a_starts;
      writes0 = a_writes;
      mem[0] = 8'd0;
      go_a = 1'b1;
      @(negedge clock);
      go_a = 1'b0;
      check("n0_busy_rdcount", a_busy, 1);
      check("n0_addr_rdcount", a_if.InputAddress, 0);
      @(negedge clock);
      check("n0_done", a_done, 1);
      check("n0_busy_done", a_busy, 0);
      @(negedge clock);
      check("n0_no_start", a_starts - starts0, 0);
      check("n0_no_we2", a_writes - writes0, 0);

      // N = 2: (3,7) cost 42, (5,1) cost 9, engine latency 10.
      mem[0] = 8'd2; mem[1] = 8'd3; mem[2] = 8'd7; mem[3] = 8'd5; mem[4] = 8'd1;
      a_lat = 10;
      eng_q.push_back('{src: 8'd3, dst: 8'd7, cost: 16'd42, nx: 1'b0});
      eng_q.push_back('{src: 8'd5, dst: 8'd1, cost: 16'd9,  nx: 1'b0});
      sb_a.push_back('{addr: 14'd0, val: 16'd42});
      sb_a.push_back('{addr: 14'd1, val: 16'd9});
      go_a = 1'b1;
      @(negedge clock);
      go_a = 1'b0;
      wait_done(1'b0, 200, "n2_done");
      check("n2_queries_done", a_qd, 2);
      check("n2_tflag", a_tflag, 0);
      check("n2_sb_drained", sb_a.size(), 0);

      // n_exist on query 0, then a source==dest query; go clears queries_done.
      mem[1] = 8'd1; mem[2] = 8'd2; mem[3] = 8'd6; mem[4] = 8'd6;
      a_lat = 4;
      eng_q.push_back('{src: 8'd1, dst: 8'd2, cost: 16'h1234, nx: 1'b1});
      eng_q.push_back('{src: 8'd6, dst: 8'd6, cost: 16'd100,  nx: 1'b0});
      sb_a.push_back('{addr: 14'd0, val: 16'hFFFF});
      sb_a.push_back('{addr: 14'd1, val: 16'd100});
      go_a = 1'b1;
      @(negedge clock);
      go_a = 1'b0;
      check("nx_qd_cleared", a_qd, 0);
      check("nx_busy", a_busy, 1);
      wait_done(1'b0, 200, "nx_done");
      check("nx_queries_done", a_qd, 2);
      check("nx_sb_drained", sb_a.size(), 0);

      // dut_b: query 0 silent -> timeout code after 8 WAIT cycles; query 1
      // finishes on the 8th WAIT cycle -> cost wins. Result address wraps.
      mem[100] = 8'd2; mem[101] = 8'd8; mem[102] = 8'd9; mem[103] = 8'd10; mem[104] = 8'd11;
      sb_b.push_back('{addr: 14'h3FFF, val: 16'hFFFE});
      sb_b.push_back('{addr: 14'h0000, val: 16'd77});
      go_b = 1'b1;
      @(negedge clock);
      go_b = 1'b0;
      wait_start_b(20, "to_start0");
      check("to_src0", b_if.engine_source, 8);
      check("to_dst0", b_if.engine_dest, 9);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!b_if.WE2 && lat < 30);
      check("to_write_latency", lat, 9);
      @(negedge clock);
      check("to_flag_set", b_tflag, 1);
      wait_start_b(20, "to_start1");
      check("to_src1", b_if.engine_source, 10);
      check("to_dst1", b_if.engine_dest, 11);
      repeat (8) @(negedge clock);
      b_if.engine_finish = 1'b1;
      b_if.engine_cost   = 16'd77;
      @(negedge clock);
      b_if.engine_finish = 1'b0;
      check("coincident_we2", b_if.WE2, 1);
      wait_done(1'b1, 20, "to_done");
      check("to_queries_done", b_qd, 2);
      check("to_flag_sticky", b_tflag, 1);
      check("to_sb_drained", sb_b.size(), 0);
      mem[100] = 8'd0;
      go_b = 1'b1;
      @(negedge clock);
      go_b = 1'b0;
      check("to_flag_cleared", b_tflag, 0);
      check("to_qd_cleared", b_qd, 0);

      // Reset while dut_a waits on the engine; rerun restarts at query 0.
      mem[0] = 8'd2; mem[1] = 8'd4; mem[2] = 8'd4; mem[3] = 8'd2; mem[4] = 8'd6;
      a_lat = 20;
      eng_q.push_back('{src: 8'd4, dst: 8'd4, cost: 16'd55, nx: 1'b0});
      writes0 = a_writes;
      go_a = 1'b1;
      @(negedge clock);
      go_a = 1'b0;
      repeat (6) @(negedge clock);
      check("rw_in_wait_busy", a_busy, 1);
      #2 reset = 1'b0;
      #1;
      check("rw_busy", a_busy, 0);
      check("rw_done", a_done, 0);
      check("rw_start", a_if.engine_start, 0);
      check("rw_src", a_if.engine_source, 0);
      check("rw_dst", a_if.engine_dest, 0);
      check("rw_addr", a_if.InputAddress, 0);
      check("rw_we2", a_if.WE2, 0);
      check("rw_qd", a_qd, 0);
      @(negedge clock);
      reset = 1'b1;
      eng_q.delete();
      @(negedge clock);
      check("rw_idle", a_busy, 0);
      a_lat = 3;
      eng_q.push_back('{src: 8'd4, dst: 8'd4, cost: 16'd11, nx: 1'b0});
      eng_q.push_back('{src: 8'd2, dst: 8'd6, cost: 16'd13, nx: 1'b0});
      sb_a.push_back('{addr: 14'd0, val: 16'd11});
      sb_a.push_back('{addr: 14'd1, val: 16'd13});
      go_a = 1'b1;
      @(negedge clock);
      go_a = 1'b0;
      wait_done(1'b0, 200, "rw_rerun_done");
      check("rw_queries_done", a_qd, 2);
      check("rw_write_count", a_writes - writes0, 2);
      check("rw_sb_drained", sb_a.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/query_scheduler.md
QUERY_SCHEDULER -- requirements
Module: query_scheduler

Interface
REQ-001 SHALL have parameter INPUT_BASE, default 10'd0, meaning input-memory word holding query count N.
REQ-002 SHALL have parameter RESULT_BASE, default 14'd0, meaning output-memory address of result for query 0.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 20000, meaning maximum WAIT cycles per query (16-bit counter).
REQ-004 SHALL have port: clock  in  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: go  in  1  start request, sampled in IDLE/DONE only.
REQ-007 SHALL have ports: InputAddress  out  10 and InputRead  in  8  query-list read port (combinational read, data valid same cycle).
REQ-008 SHALL have ports: engine_start  out  1, engine_source  out  8, engine_dest  out  8  shortest-path engine launch.
REQ-009 SHALL have ports: engine_finish  in  1, engine_n_exist  in  1, engine_cost  in  16  engine completion and result.
REQ-010 SHALL have ports: WE2  out  1, output_memory_address  out  14, output_memory_value  out  16  result write port.
REQ-011 SHALL have ports: busy  out  1, done  out  1, timeout_flag  out  1, queries_done  out  8  status.

Function
REQ-012 SHALL implement FSM states IDLE, RD_COUNT, RD_SRC, RD_DST, START, WAIT, WR_RES, DONE.
REQ-013 SHALL move IDLE/DONE -> RD_COUNT on go=1; go in any other state ignored.
REQ-014 SHALL drive InputAddress = INPUT_BASE in RD_COUNT, latch N = InputRead at end of cycle; N=0 -> DONE, else RD_SRC.
REQ-015 SHALL drive InputAddress = INPUT_BASE+1+2i in RD_SRC and INPUT_BASE+2+2i in RD_DST for query i (0..N-1), latching source and dest.
REQ-016 SHALL assert engine_start for exactly one cycle in START; engine_source/engine_dest held stable from START until leaving WAIT.
REQ-017 SHALL sample engine_finish only in WAIT; finish=1 -> WR_RES capturing cost and n_exist.
REQ-018 SHALL count WAIT cycles; count reaching TIMEOUT_CYCLES without finish -> WR_RES with timeout result and timeout_flag set (sticky until next go).
REQ-019 SHALL give engine_finish priority over timeout when both occur in the same cycle.
REQ-020 SHALL in WR_RES assert WE2 one cycle, address RESULT_BASE+i (14-bit wrap), value: n_exist -> 16'hFFFF; timeout -> 16'hFFFE; else engine_cost.
REQ-021 SHALL increment i and queries_done in WR_RES; i=N-1 -> DONE, else RD_SRC.
REQ-022 SHALL hold busy=1 in all states except IDLE and DONE; done=1 only in DONE.
REQ-023 SHALL clear queries_done and timeout_flag on go accepted in IDLE/DONE.
REQ-024 SHALL dispatch source==dest queries normally (no shortcut).
REQ-025 SHALL cost per query 5 cycles plus engine latency (RD_SRC, RD_DST, START, WR_RES, +1 WAIT minimum).

Reset
REQ-026 SHALL on reset=0, asynchronously, enter IDLE, clear i, N, counters, latched source/dest, queries_done, timeout_flag.
REQ-027 SHALL drive all outputs to 0 during and after reset until go, including mid-query (no result write issued).

Structure
REQ-028 SHALL place FSM state encoding and reserved result codes (16'hFFFF, 16'hFFFE) in shared package graph_pkg.
REQ-029 SHALL be a single module; timeout counter MAY be sub-module wait_timer.

Verification
REQ-030 SHALL test N=0: go -> RD_COUNT -> DONE in 2 cycles, no engine_start, no WE2.
REQ-031 SHALL test N=2, queries (3,7),(5,1), engine finishing 10 cycles after start with costs 42, 9 -> writes RESULT_BASE=42, RESULT_BASE+1=9, queries_done=2, done=1.
REQ-032 SHALL test n_exist=1 on query 0 -> output_memory_value=16'hFFFF, scheduler continues to query 1.
REQ-033 SHALL test TIMEOUT_CYCLES=8, engine silent -> 16'hFFFE written after 8 WAIT cycles, timeout_flag=1; finish and timeout coincident -> engine_cost written.
REQ-034 SHALL test reset asserted in WAIT -> all outputs 0 immediately, no WE2, next go restarts from query 0.
